// File: rtl/decoder_scan.sv
// decoder_scan -- registered N-to-2**N one-hot decoder with an auto-scan mode.
//
// Parameters
//   N    index width; d is 2**N bits wide
//   DIV  clock cycles per scan step (>= 1)
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   en    block enable (0 forces d to zero)
//   mode  0 = direct decode of a, 1 = auto-scan
//   a     direct-decode address / scan start index
//   last  highest scan index (inclusive)
//   dir   scan direction, 0 = up, 1 = down
//   d     registered one-hot of idx (zero when disabled)
//   idx   registered index currently decoded
//   wrap  one-cycle pulse after a wrapping scan step
module decoder_scan #(
  parameter int N   = 3,
  parameter int DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic [N-1:0]      a,
  input  logic [N-1:0]      last,
  input  logic              dir,
  output logic [2**N-1:0]   d,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [PW-1:0] PONE = PW'(1);
  localparam logic [N-1:0]  IONE = N'(1);

  localparam logic [1:0] OFF    = 2'd0;
  localparam logic [1:0] DIRECT = 2'd1;
  localparam logic [1:0] SCAN   = 2'd2;

  logic [1:0]        state, nstate;
  logic [PW-1:0]     pre, npre;
  logic [N-1:0]      nidx;
  logic              nwrap;
  logic              don;
  logic [2**N-1:0]   nd;

  // Next-state and datapath are resolved together so that d is always the
  // one-hot of the index being loaded on the same edge.
  always_comb begin
    nstate = !en ? OFF : (!mode ? DIRECT : SCAN);
    nidx   = idx;
    npre   = '0;
    nwrap  = 1'b0;
    don    = 1'b1;
    case (nstate)
      OFF: begin
        don = 1'b0;
      end
      DIRECT: begin
        nidx = a;
      end
      default: begin
        if (state != SCAN) begin
          // Entry: start index clamped to the scan range.
          nidx = (a > last) ? last : a;
        end else if (pre == PMAX) begin
          if (!dir) begin
            if (idx >= last) begin
              nidx  = '0;
              nwrap = 1'b1;
            end else begin
              nidx = idx + IONE;
            end
          end else begin
            if (idx == '0) begin
              nidx  = last;
              nwrap = 1'b1;
            end else if (idx > last) begin
              nidx = last;
            end else begin
              nidx = idx - IONE;
            end
          end
        end else begin
          npre = pre + PONE;
        end
      end
    endcase
    nd = '0;
    if (don) nd[nidx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
      pre   <= '0;
      idx   <= '0;
      d     <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= nstate;
      pre   <= npre;
      idx   <= nidx;
      d     <= nd;
      wrap  <= nwrap;
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan -- self-checking bench for decoder_scan. Two instances
// (DIV=4 and DIV=1) share the same stimulus; each is compared every cycle
// against a rule-level reference model.
module tb_decoder_scan;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst, en, mode, dir;
  logic [N-1:0] a, last;
  logic [7:0]   d0, d1;
  logic [N-1:0] idx0, idx1;
  logic         wrap0, wrap1;

  int tests  = 0;
  int errors = 0;

  // Reference model state, one slot per instance.
  int divs [2] = '{4, 1};
  int m_idx[2];
  int m_pre[2];
  int m_st [2];   // 0 = off, 1 = direct, 2 = scan
  int m_wrap[2];
  int m_on [2];

  always #5 clk = ~clk;

  decoder_scan #(.N(N), .DIV(4)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .last(last),
    .dir(dir), .d(d0), .idx(idx0), .wrap(wrap0)
  );

  decoder_scan #(.N(N), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .last(last),
    .dir(dir), .d(d1), .idx(idx1), .wrap(wrap1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One edge of behaviour for instance k, from the inputs applied now.
  task automatic model(input int k);
    int ia, il;
    ia = int'(a);
    il = int'(last);
    if (rst) begin
      m_st[k] = 0; m_idx[k] = 0; m_pre[k] = 0; m_wrap[k] = 0; m_on[k] = 0;
    end else if (!en) begin
      m_st[k] = 0; m_pre[k] = 0; m_wrap[k] = 0; m_on[k] = 0;
    end else if (!mode) begin
      m_st[k] = 1; m_idx[k] = ia; m_pre[k] = 0; m_wrap[k] = 0; m_on[k] = 1;
    end else if (m_st[k] != 2) begin
      m_st[k] = 2; m_idx[k] = (ia < il) ? ia : il; m_pre[k] = 0;
      m_wrap[k] = 0; m_on[k] = 1;
    end else if (m_pre[k] == divs[k] - 1) begin
      m_pre[k] = 0;
      m_wrap[k] = 0;
      if (!dir) begin
        if (m_idx[k] >= il) begin m_idx[k] = 0; m_wrap[k] = 1; end
        else m_idx[k] = (m_idx[k] + 1) % 8;
      end else begin
        if (m_idx[k] == 0) begin m_idx[k] = il; m_wrap[k] = 1; end
        else if (m_idx[k] > il) m_idx[k] = il;
        else m_idx[k] = m_idx[k] - 1;
      end
    end else begin
      m_pre[k] = m_pre[k] + 1;
      m_wrap[k] = 0;
    end
  endtask

  task automatic cycle();
    int ed;
    model(0);
    model(1);
    @(posedge clk);
    #1;
    ed = m_on[0] ? (1 << m_idx[0]) : 0;
    check("d_div4", 32'(d0), 32'(ed));
    check("idx_div4", 32'(idx0), 32'(m_idx[0]));
    check("wrap_div4", 32'(wrap0), 32'(m_wrap[0]));
    ed = m_on[1] ? (1 << m_idx[1]) : 0;
    check("d_div1", 32'(d1), 32'(ed));
    check("idx_div1", 32'(idx1), 32'(m_idx[1]));
    check("wrap_div1", 32'(wrap1), 32'(m_wrap[1]));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int budget;
    rst = 1'b1; en = 1'b1; mode = 1'b1; dir = 1'b0; a = 3'd5; last = 3'd7;
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_idx[k] = 0; m_pre[k] = 0; m_wrap[k] = 0; m_on[k] = 0;
    end
    cycle();
    check("rst_d", 32'(d0), 32'h0);
    check("rst_idx", 32'(idx0), 32'h0);
    check("rst_wrap", 32'(wrap0), 32'h0);
    rst = 1'b0;

    // Direct decode sweep, then disable.
    mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a = 3'(i);
      cycle();
      check("direct_onehot", 32'(d0), 32'(1 << i));
    end
    en = 1'b0;
    cycle();
    check("disable_d", 32'(d0), 32'h0);

    // Up scan 0..5.
    en = 1'b1; mode = 1'b0; a = 3'd0; last = 3'd5; dir = 1'b0;
    cycle();
    mode = 1'b1;
    run(30);

    // Down scan with clamped entry.
    mode = 1'b0; a = 3'd6; last = 3'd3; dir = 1'b1;
    cycle();
    mode = 1'b1;
    cycle();
    check("clamp_entry", 32'(idx0), 32'd3);
    run(20);

    // last = 0, then raise to reach idx 5 on the DIV=1 instance, then lower.
    mode = 1'b0; a = 3'd0; last = 3'd0; dir = 1'b0;
    cycle();
    mode = 1'b1;
    run(6);
    check("last0_wrap", 32'(wrap1), 32'h1);
    last = 3'd7;
    budget = 0;
    while (idx1 != 3'd5 && budget < 50) begin cycle(); budget++; end
    if (budget >= 50) check("wait_idx5", 32'h0, 32'h1);
    last = 3'd2;
    cycle();
    check("lowered_last_idx", 32'(idx1), 32'h0);
    check("lowered_last_wrap", 32'(wrap1), 32'h1);
    run(8);

    // Reset mid-scan at idx 4 on the DIV=4 instance.
    last = 3'd7; a = 3'd2;
    budget = 0;
    while (idx0 != 3'd4 && budget < 100) begin cycle(); budget++; end
    if (budget >= 100) check("wait_idx4", 32'h0, 32'h1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(12);

    // en dropped on an edge where a step is due.
    budget = 0;
    while (m_pre[0] != 3 && budget < 20) begin cycle(); budget++; end
    if (budget >= 20) check("wait_step", 32'h0, 32'h1);
    en = 1'b0;
    cycle();
    check("drop_wrap", 32'(wrap0), 32'h0);
    en = 1'b1;
    run(4);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(63) == 0);
      en  = ($urandom_range(15) != 0);
      if ($urandom_range(31) == 0) mode = ~mode;
      if ($urandom_range(15) == 0) dir = ~dir;
      if ($urandom_range(15) == 0) last = 3'($urandom_range(7));
      a = 3'($urandom_range(7));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
